// File: rtl/decode_pkg.sv
// Shared types and helpers for the 2-to-4 pulse decoder.
package decode_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

  function automatic logic [3:0] onehot4(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

endpackage

// File: rtl/fifo2.sv
// Two-entry FIFO; slot0 is always the head. Push and pop may share a cycle,
// push into a full FIFO is ignored unless a pop frees the slot that cycle.
module fifo2 #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] slot0_r;
  logic [W-1:0] slot1_r;
  logic [1:0]   count_r;
  logic         pop_ok_s;
  logic         push_ok_s;

  assign pop_ok_s  = pop && (count_r != 2'd0);
  assign push_ok_s = push && ((count_r != 2'd2) || pop_ok_s);

  // storage and occupancy update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_r <= '0;
      slot1_r <= '0;
      count_r <= 2'd0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            slot0_r <= din;
          end else begin
            slot1_r <= din;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          slot0_r <= slot1_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            slot0_r <= din;
          end else begin
            slot0_r <= slot1_r;
            slot1_r <= din;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign dout  = slot0_r;
  assign count = count_r;

endmodule

// File: rtl/decode24_pulse.sv
// Sequential 2-to-4 decoder: buffered codes become one-hot pulses of
// PULSE_LEN cycles, each followed by GAP_LEN all-zero cycles.
module decode24_pulse
  import decode_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] a,
  output logic       in_ready,
  output logic [3:0] d,
  output logic       done,
  output logic       busy
);

  localparam logic [7:0] PULSE_RELOAD = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GAP_RELOAD   = 8'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);

  state_e     state_r;
  state_e     state_nx_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_nx_s;
  logic [3:0] d_r;
  logic [3:0] d_nx_s;
  logic       pop_s;
  logic       push_s;
  logic       fifo_ne_s;
  logic [1:0] head_s;
  logic [1:0] count_s;

  // ready depends only on registered occupancy, never on this cycle's pop
  assign in_ready  = (count_s != 2'd2);
  assign push_s    = in_valid && in_ready;
  assign fifo_ne_s = (count_s != 2'd0);

  fifo2 #(.W(2)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (a),
    .pop   (pop_s),
    .dout  (head_s),
    .count (count_s)
  );

  // next-state, counter and output selection
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    d_nx_s     = d_r;
    pop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (fifo_ne_s) begin
          pop_s      = 1'b1;
          d_nx_s     = onehot4(head_s);
          cnt_nx_s   = PULSE_RELOAD;
          state_nx_s = PULSE;
        end else begin
          d_nx_s = 4'b0000;
        end
      end
      PULSE: begin
        if (cnt_r != 8'd0) begin
          cnt_nx_s = cnt_r - 8'd1;
        end else if (GAP_LEN > 0) begin
          d_nx_s     = 4'b0000;
          cnt_nx_s   = GAP_RELOAD;
          state_nx_s = GAP;
        end else if (fifo_ne_s) begin
          // back-to-back pulses: switch one-hot to one-hot without a zero cycle
          pop_s      = 1'b1;
          d_nx_s     = onehot4(head_s);
          cnt_nx_s   = PULSE_RELOAD;
          state_nx_s = PULSE;
        end else begin
          d_nx_s     = 4'b0000;
          state_nx_s = IDLE;
        end
      end
      GAP: begin
        if (cnt_r != 8'd0) begin
          cnt_nx_s = cnt_r - 8'd1;
        end else if (fifo_ne_s) begin
          pop_s      = 1'b1;
          d_nx_s     = onehot4(head_s);
          cnt_nx_s   = PULSE_RELOAD;
          state_nx_s = PULSE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      default: begin
        d_nx_s     = 4'b0000;
        cnt_nx_s   = 8'd0;
        state_nx_s = IDLE;
      end
    endcase
  end

  // state, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      d_r     <= 4'b0000;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      d_r     <= d_nx_s;
    end
  end

  assign d    = d_r;
  assign done = (state_r == PULSE) && (cnt_r == 8'd0);
  assign busy = (state_r != IDLE) || fifo_ne_s;

endmodule

// File: tb/tb_decode24_pulse.sv
// Bench for decode24_pulse: three instances (4/1, 1/0, 255/1) with a
// per-instance scoreboard of accepted codes plus directed timing sequences.
module tb_decode24_pulse;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_valid_s;
  logic [2:0] in_ready_s;
  logic [2:0] done_s;
  logic [2:0] busy_s;
  logic [1:0] a_s [3];
  logic [3:0] d_s [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode24_pulse #(.PULSE_LEN(4), .GAP_LEN(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .a(a_s[0]),
    .in_ready(in_ready_s[0]), .d(d_s[0]), .done(done_s[0]), .busy(busy_s[0]));
  decode24_pulse #(.PULSE_LEN(1), .GAP_LEN(0)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .a(a_s[1]),
    .in_ready(in_ready_s[1]), .d(d_s[1]), .done(done_s[1]), .busy(busy_s[1]));
  decode24_pulse #(.PULSE_LEN(255), .GAP_LEN(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[2]), .a(a_s[2]),
    .in_ready(in_ready_s[2]), .d(d_s[2]), .done(done_s[2]), .busy(busy_s[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: codes queued on acceptance, popped when a new pulse starts
  logic [1:0] sb [3][$];
  logic [3:0] prev_d [3];
  logic       prev_done [3];
  int         run_len [3];
  int         plen [3] = '{4, 1, 255};
  logic [1:0] mon_code;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        sb[i].delete();
        prev_d[i]    = 4'b0000;
        prev_done[i] = 1'b0;
        run_len[i]   = 0;
      end else begin
        check($sformatf("onehot%0d", i), 32'($countones(d_s[i]) <= 1), 32'd1);
        if (d_s[i] != 4'b0000) begin
          if (prev_d[i] == 4'b0000 || prev_done[i]) begin
            if (sb[i].size() == 0) begin
              check($sformatf("unexpected_pulse%0d", i), 32'(d_s[i]), 32'd0);
            end else begin
              mon_code = sb[i].pop_front();
              check($sformatf("order%0d", i), 32'(d_s[i]), 32'(4'b0001 << mon_code));
            end
            run_len[i] = 1;
          end else begin
            check($sformatf("hold%0d", i), 32'(d_s[i]), 32'(prev_d[i]));
            run_len[i]++;
          end
        end
        if (done_s[i]) check($sformatf("pulse_len%0d", i), 32'(run_len[i]), 32'(plen[i]));
        if (in_valid_s[i] && in_ready_s[i]) sb[i].push_back(a_s[i]);
        prev_d[i]    = d_s[i];
        prev_done[i] = done_s[i];
      end
    end
  end

  typedef struct {
    logic [1:0] code;
    logic [3:0] exp_d;
  } vec_t;

  vec_t vecs [4];
  int   codes [4] = '{0, 1, 2, 3};
  int   acc_edge [4];

  initial begin
    int         i;
    int         n;
    int         slot;
    int         pos;
    logic       acc;
    logic       exp_rdy;
    logic [3:0] exp_d;

    vecs[0] = '{code: 2'd2, exp_d: 4'b0100};
    vecs[1] = '{code: 2'd0, exp_d: 4'b0001};
    vecs[2] = '{code: 2'd3, exp_d: 4'b1000};
    vecs[3] = '{code: 2'd1, exp_d: 4'b0010};

    rst        = 1'b1;
    in_valid_s = 3'b000;
    for (int k = 0; k < 3; k++) a_s[k] = 2'd0;
    #2;
    for (int k = 0; k < 3; k++) begin
      check("rst_d", 32'(d_s[k]), 32'd0);
      check("rst_done", 32'(done_s[k]), 32'd0);
      check("rst_busy", 32'(busy_s[k]), 32'd0);
      check("rst_ready", 32'(in_ready_s[k]), 32'd1);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();

    // single codes: latency, pulse length, done position, gap and busy
    foreach (vecs[v]) begin
      in_valid_s[0] = 1'b1;
      a_s[0]        = vecs[v].code;
      tick();
      in_valid_s[0] = 1'b0;
      check("lat_k_d", 32'(d_s[0]), 32'd0);
      check("lat_k_busy", 32'(busy_s[0]), 32'd1);
      for (int c = 1; c <= 4; c++) begin
        tick();
        check("pulse_d", 32'(d_s[0]), 32'(vecs[v].exp_d));
        check("pulse_done", 32'(done_s[0]), 32'(c == 4));
      end
      tick();
      check("gap_d", 32'(d_s[0]), 32'd0);
      check("gap_busy", 32'(busy_s[0]), 32'd1);
      check("gap_done", 32'(done_s[0]), 32'd0);
      tick();
      check("idle_busy", 32'(busy_s[0]), 32'd0);
    end

    // all codes with in_valid held: back-pressure, order and exact waveform
    i             = 0;
    in_valid_s[0] = 1'b1;
    a_s[0]        = 2'(codes[0]);
    for (int t = 0; t <= 20; t++) begin
      @(negedge clk);
      exp_rdy = !((t >= 3 && t <= 6) || (t >= 8 && t <= 11));
      check("ready", 32'(in_ready_s[0]), 32'(exp_rdy));
      acc = in_valid_s[0] && in_ready_s[0];
      @(posedge clk);
      #1;
      if (acc) begin
        acc_edge[i] = t;
        i++;
        if (i == 4) in_valid_s[0] = 1'b0;
        else a_s[0] = 2'(codes[i]);
      end
      if (t >= 1) begin
        slot  = (t - 1) / 5;
        pos   = (t - 1) % 5;
        exp_d = (pos < 4) ? (4'b0001 << slot) : 4'b0000;
        check("seq_d", 32'(d_s[0]), 32'(exp_d));
      end
    end
    check("accepted", 32'(i), 32'd4);
    check("acc_edge0", 32'(acc_edge[0]), 32'd0);
    check("acc_edge1", 32'(acc_edge[1]), 32'd1);
    check("acc_edge2", 32'(acc_edge[2]), 32'd2);
    check("acc_edge3", 32'(acc_edge[3]), 32'd7);
    tick();
    check("seq_idle_busy", 32'(busy_s[0]), 32'd0);

    // PULSE_LEN=1, GAP_LEN=0: one-hot to one-hot, done on both cycles
    in_valid_s[1] = 1'b1;
    a_s[1]        = 2'd3;
    tick();
    a_s[1] = 2'd1;
    check("g0_k_d", 32'(d_s[1]), 32'd0);
    tick();
    in_valid_s[1] = 1'b0;
    check("g0_d1", 32'(d_s[1]), 32'b1000);
    check("g0_done1", 32'(done_s[1]), 32'd1);
    tick();
    check("g0_d2", 32'(d_s[1]), 32'b0010);
    check("g0_done2", 32'(done_s[1]), 32'd1);
    tick();
    check("g0_d3", 32'(d_s[1]), 32'd0);
    check("g0_done3", 32'(done_s[1]), 32'd0);
    check("g0_busy3", 32'(busy_s[1]), 32'd0);

    // reset during the second pulse cycle with one code buffered
    in_valid_s[0] = 1'b1;
    a_s[0]        = 2'd1;
    tick();
    a_s[0] = 2'd2;
    tick();
    in_valid_s[0] = 1'b0;
    tick();
    check("mid_d", 32'(d_s[0]), 32'b0010);
    check("mid_busy", 32'(busy_s[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("async_d", 32'(d_s[0]), 32'd0);
    check("async_busy", 32'(busy_s[0]), 32'd0);
    check("async_ready", 32'(in_ready_s[0]), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("post_rst_d", 32'(d_s[0]), 32'd0);
      check("post_rst_busy", 32'(busy_s[0]), 32'd0);
    end
    in_valid_s[0] = 1'b1;
    a_s[0]        = 2'd3;
    tick();
    in_valid_s[0] = 1'b0;
    n = 0;
    while (busy_s[0] && n < 20) begin
      tick();
      n++;
    end
    check("post_rst_drain", 32'(busy_s[0]), 32'd0);

    // PULSE_LEN=255 boundary
    in_valid_s[2] = 1'b1;
    a_s[2]        = 2'd1;
    tick();
    in_valid_s[2] = 1'b0;
    tick();
    n = 0;
    while (d_s[2] == 4'b0010 && n < 300) begin
      n++;
      tick();
    end
    check("long_len", 32'(n), 32'd255);
    check("long_gap_d", 32'(d_s[2]), 32'd0);
    check("long_gap_busy", 32'(busy_s[2]), 32'd1);
    tick();
    check("long_idle_busy", 32'(busy_s[2]), 32'd0);

    tick();
    for (int k = 0; k < 3; k++) check($sformatf("sb_empty%0d", k), 32'(sb[k].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
